// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot loader assembling a byte stream into 32-bit LE words written to instruction memory.
// Ports: clk, rst (async active-low), start (restart pulse); rx_valid/rx_data/rx_ready byte stream;
// wr_en/wr_adr/wr_data word write port; core_rst_n core reset; done/error/err_code load status.
// Define LOADER_CHECKSUM_EN to append and verify an XOR checksum byte after the data words.
module inst_mem_loader #(
  parameter int ADR_WIDTH = 11,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [ADR_WIDTH-1:0] wr_adr,
  output logic [31:0]          wr_data,
  output logic                 core_rst_n,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);
  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR} state_t;
  localparam logic [CNT_WIDTH:0] MAX_CNT = (CNT_WIDTH + 1)'(1) << ADR_WIDTH;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
`else
  localparam state_t FIN = DONE;
`endif
  state_t                 r_state, w_next;
  logic [7:0]             r_cnt_lo;
  logic [CNT_WIDTH-1:0]   r_cnt, r_wcnt, w_cnt;
  logic [1:0]             r_bidx, r_err;
  logic [23:0]            r_sh;
  logic [31:0]            r_wr_data;
  logic [ADR_WIDTH-1:0]   r_wr_adr;
  logic                   r_wr_en, r_core, w_acc, w_big, w_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif
  // start wins over a coincident handshake, so such a byte is never consumed
  assign w_acc  = rx_valid && rx_ready && !start;
  assign w_cnt  = CNT_WIDTH'({rx_data, r_cnt_lo});
  assign w_big  = {1'b0, w_cnt} > MAX_CNT;
  assign w_last = (r_wcnt + CNT_WIDTH'(1)) == r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CNT_LO;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (start) w_next = CNT_LO;
    else if (w_acc)
      case (r_state)
        CNT_LO:  w_next = CNT_HI;
        CNT_HI:  w_next = w_big ? ERROR : (w_cnt == '0 ? FIN : DATA);
        // leave DATA as the last word's write is issued so a following byte is never taken as data
        DATA:    w_next = (r_bidx == 2'd3 && w_last) ? FIN : DATA;
`ifdef LOADER_CHECKSUM_EN
        CSUM:    w_next = rx_data == r_csum ? DONE : ERROR;
`endif
        default: w_next = r_state;
      endcase
  end
  always_comb begin
    rx_ready   = r_state inside {CNT_LO, CNT_HI, DATA, CSUM};
    done       = r_state == DONE;
    error      = r_state == ERROR;
    err_code   = r_err;
    wr_en      = r_wr_en && !start;
    wr_adr     = r_wr_adr;
    wr_data    = r_wr_data;
    core_rst_n = r_core;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_lo  <= '0;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_bidx    <= '0;
      r_err     <= '0;
      r_sh      <= '0;
      r_wr_data <= '0;
      r_wr_adr  <= '0;
      r_wr_en   <= 1'b0;
      r_core    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_wr_en <= w_acc && r_state == DATA && r_bidx == 2'd3;
      // released one cycle after DONE so the last word's write has completed
      r_core  <= r_state == DONE && !start;
      if (start) begin
        r_wcnt   <= '0;
        r_bidx   <= '0;
        r_err    <= '0;
        r_wr_adr <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_csum   <= '0;
`endif
      end else if (w_acc) begin
        if (r_state == CNT_LO) r_cnt_lo <= rx_data;
        if (r_state == CNT_HI) begin
          r_cnt <= w_cnt;
          if (w_big) r_err <= 2'b01;
        end
        if (r_state == DATA) begin
          r_bidx <= r_bidx + 2'd1;
          r_sh   <= {rx_data, r_sh[23:8]};
          if (r_bidx == 2'd3) begin
            r_wr_data <= {rx_data, r_sh};
            r_wr_adr  <= r_wcnt[ADR_WIDTH-1:0];
            r_wcnt    <= r_wcnt + CNT_WIDTH'(1);
          end
        end
`ifdef LOADER_CHECKSUM_EN
        if (r_state inside {CNT_LO, CNT_HI, DATA}) r_csum <= r_csum ^ rx_data;
        if (r_state == CSUM && rx_data != r_csum) r_err <= 2'b10;
`endif
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for inst_mem_loader (honours LOADER_CHECKSUM_EN).
module tb_inst_mem_loader;
  localparam int AW = 11;
  logic clk = 0, rst = 0, start = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic rx_ready, wr_en, core_rst_n, done, error;
  logic [AW-1:0] wr_adr;
  logic [31:0] wr_data;
  logic [1:0] err_code;
  int vectors = 0, errs = 0;
  logic [7:0] tb_csum;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] m_exp;
  inst_mem_loader #(.ADR_WIDTH(AW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .core_rst_n(core_rst_n), .done(done), .error(error), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst && wr_en) begin
    vectors++;
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL write: unexpected write adr=%h data=%h", wr_adr, wr_data);
    end else begin
      m_exp = exp_q.pop_front();
      if ({wr_adr, wr_data} !== m_exp) begin
        errs++;
        $display("FAIL write: got adr=%h data=%h want adr=%h data=%h", wr_adr, wr_data, m_exp[AW+31:32], m_exp[31:0]);
      end
    end
  end
  function automatic logic [31:0] word_of(input int w);
    return w == 0 ? 32'h00500093 : w == 1 ? 32'h00100113 : $urandom;
  endfunction
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    while (!rx_ready && n < 16) begin @(negedge clk); n++; end
    vectors++;
    if (!rx_ready) begin
      errs++;
      $display("FAIL rx_ready: got 0 want 1 for byte %h", b);
    end else begin
      rx_valid = 1; rx_data = b; tb_csum ^= b;
      @(negedge clk);
      rx_valid = 0;
    end
  endtask
  task automatic load(input int cnt, input int gmax, input logic bad);
    logic [31:0] w;
    logic [7:0] c;
    tb_csum = 0;
    send_byte(cnt[7:0], $urandom_range(gmax, 0));
    send_byte(cnt[15:8], $urandom_range(gmax, 0));
    for (int i = 0; i < cnt; i++) begin
      w = word_of(i);
      for (int k = 0; k < 4; k++) begin
        if (k == 3) exp_q.push_back({AW'(i), w});
        send_byte(w[8*k +: 8], $urandom_range(gmax, 0));
      end
    end
    c = bad ? tb_csum ^ 8'h07 : tb_csum;
`ifdef LOADER_CHECKSUM_EN
    send_byte(c, $urandom_range(gmax, 0));
`endif
  endtask
  task automatic check_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (done !== 1 || core_rst_n !== 0 || error !== 0) begin
      errs++;
      $display("FAIL %s done: got done=%b core_rst_n=%b error=%b want 1 0 0", tag, done, core_rst_n, error);
    end
    @(negedge clk);
    vectors++;
    if (core_rst_n !== 1 || rx_ready !== 0 || done !== 1) begin
      errs++;
      $display("FAIL %s release: got core_rst_n=%b rx_ready=%b done=%b want 1 0 1", tag, core_rst_n, rx_ready, done);
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL %s writes: got %0d missing want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    vectors++;
    if ({core_rst_n, done, error, err_code, rx_ready} !== 6'b000001) begin
      errs++;
      $display("FAIL start: got core_rst_n=%b done=%b error=%b err_code=%b rx_ready=%b want 0 0 0 00 1",
               core_rst_n, done, error, err_code, rx_ready);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_ready, wr_en, core_rst_n, done, error, err_code, wr_adr, wr_data} !== {1'b1, 6'b0, {AW{1'b0}}, 32'h0}) begin
      errs++;
      $display("FAIL reset: got rx_ready=%b wr_en=%b core=%b done=%b error=%b code=%b adr=%h data=%h",
               rx_ready, wr_en, core_rst_n, done, error, err_code, wr_adr, wr_data);
    end
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({rx_ready, wr_en, core_rst_n, done, error} !== 5'b10000) begin
        errs++;
        $display("FAIL idle cycle %0d: got rx_ready=%b wr_en=%b core=%b done=%b error=%b want 1 0 0 0 0",
                 i, rx_ready, wr_en, core_rst_n, done, error);
      end
    end
  endtask
  task automatic test_basic();
    load(2, 0, 1'b0);
    check_done("basic");
  endtask
  task automatic test_gaps();
    pulse_start();
    load(2, 5, 1'b0);
    check_done("gaps");
  endtask
`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    pulse_start();
    load(2, 0, 1'b1);
    vectors++;
    if ({error, err_code, core_rst_n, rx_ready, done} !== 6'b110000) begin
      errs++;
      $display("FAIL bad_csum: got error=%b code=%b core=%b rx_ready=%b done=%b want 1 10 0 0 0",
               error, err_code, core_rst_n, rx_ready, done);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL bad_csum writes: got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`endif
  task automatic test_overflow();
    pulse_start();
    tb_csum = 0;
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    repeat (2) begin
      vectors++;
      if ({error, err_code, core_rst_n, rx_ready, done} !== 6'b101000) begin
        errs++;
        $display("FAIL overflow: got error=%b code=%b core=%b rx_ready=%b done=%b want 1 01 0 0 0",
                 error, err_code, core_rst_n, rx_ready, done);
      end
      repeat (5) @(negedge clk);
    end
  endtask
  task automatic test_start_mid();
    logic [31:0] w;
    pulse_start();
    tb_csum = 0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    w = word_of(0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) exp_q.push_back({AW'(0), w});
      send_byte(w[8*k +: 8], 0);
    end
    w = word_of(1);
    send_byte(w[7:0], 1);
    send_byte(w[15:8], 0);
    rx_valid = 1; rx_data = 8'hAA; start = 1;
    @(negedge clk);
    rx_valid = 0; start = 0;
    vectors++;
    if ({core_rst_n, done, error, rx_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL start_mid: got core=%b done=%b error=%b rx_ready=%b want 0 0 0 1", core_rst_n, done, error, rx_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL start_mid writes: got %0d missing want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    load(2, 1, 1'b0);
    check_done("start_reload");
  endtask
  task automatic test_counts();
    pulse_start();
    load(0, 0, 1'b0);
    check_done("zero");
    pulse_start();
    load(2048, 0, 1'b0);
    check_done("max");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_overflow();
    test_start_mid();
    test_counts();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
